user_code_loader: RTL and testbench

Boot-time loader that copies the 16 hardwired high-bank instruction words (b0I..b15I from the user code ROM) into the writable instruction memory of the i281 CPU, then reads every word back and compares it. It sits between the code ROM and the instruction memory write/read ports. It holds the CPU core in reset (cpu_hold) until the image is loaded and verified.

---
 rtl/user_code_loader.sv | 203 ++++++++++++++++++++
 tb/tb_user_code_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_code_loader.sv
// Boot loader: copies the hardwired user code words into instruction
// memory, reads each one back to verify, and holds the CPU until done.
//
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   b0I..b15I           static code words from the user code ROM
//   start               (re)load request, honoured in IDLE/DONE/FAIL
//   wr_en/wr_addr/wr_data/wr_ready   instruction memory write port
//   rd_addr/rd_data     read-back port, data valid one cycle after addr
//   cpu_hold            CPU reset hold, low only once verified
//   done/error/error_addr            load status
module user_code_loader #(
    parameter int BASE_ADDR  = 16,
    parameter int NUM_WORDS  = 16,
    parameter int ADDR_W     = 5,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       b0I,
    input  logic [15:0]       b1I,
    input  logic [15:0]       b2I,
    input  logic [15:0]       b3I,
    input  logic [15:0]       b4I,
    input  logic [15:0]       b5I,
    input  logic [15:0]       b6I,
    input  logic [15:0]       b7I,
    input  logic [15:0]       b8I,
    input  logic [15:0]       b9I,
    input  logic [15:0]       b10I,
    input  logic [15:0]       b11I,
    input  logic [15:0]       b12I,
    input  logic [15:0]       b13I,
    input  logic [15:0]       b14I,
    input  logic [15:0]       b15I,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] error_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic                auto_q, auto_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic                load;
    logic [15:0]         words [16];

    assign words[0]  = b0I;
    assign words[1]  = b1I;
    assign words[2]  = b2I;
    assign words[3]  = b3I;
    assign words[4]  = b4I;
    assign words[5]  = b5I;
    assign words[6]  = b6I;
    assign words[7]  = b7I;
    assign words[8]  = b8I;
    assign words[9]  = b9I;
    assign words[10] = b10I;
    assign words[11] = b11I;
    assign words[12] = b12I;
    assign words[13] = b13I;
    assign words[14] = b14I;
    assign words[15] = b15I;

    // Address wraps modulo 2^ADDR_W by truncation.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] i);
        return ADDR_W'(BASE_ADDR + int'(i));
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        auto_d     = auto_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        load       = 1'b0;

        unique case (state_q)
            S_IDLE: load = start || auto_q;
            S_WRITE: begin
                if (wr_en_q && wr_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        wr_en_d   = 1'b0;
                        rd_addr_d = addr_of(4'd0);
                        state_d   = S_VERIFY;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        wr_addr_d = addr_of(idx_q + 4'd1);
                        wr_data_d = words[idx_q + 4'd1];
                    end
                end
            end
            // One cycle for the memory to return the addressed word.
            S_VERIFY: state_d = S_CHECK;
            S_CHECK: begin
                if (rd_data == words[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        rd_addr_d = addr_of(idx_q + 4'd1);
                        state_d   = S_VERIFY;
                    end
                end else begin
                    idx_d      = '0;
                    error_d    = 1'b1;
                    err_addr_d = addr_of(idx_q);
                    state_d    = S_FAIL;
                end
            end
            S_DONE, S_FAIL: load = start;
            default: state_d = S_IDLE;
        endcase

        // Every load starts from word 0 with status cleared and CPU held.
        if (load) begin
            state_d    = S_WRITE;
            idx_d      = '0;
            auto_d     = 1'b0;
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_of(4'd0);
            wr_data_d  = words[0];
            hold_d     = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            auto_q     <= AUTO_START;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            auto_q     <= auto_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_addr    = rd_addr_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign error_addr = err_addr_q;

endmodule

// File: tb/tb_user_code_loader.sv
// Bench for user_code_loader: memory model, write scoreboard,
// scenario table plus restart / abort / short-image sequences.
module tb_user_code_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, rst9_n, start, wr_ready;
    logic [15:0] rom [16];

    logic        wr_en, cpu_hold, done, error;
    logic [4:0]  wr_addr, rd_addr, error_addr;
    logic [15:0] wr_data, rd_data;

    logic        wr_en9, cpu_hold9, done9, error9;
    logic [4:0]  wr_addr9, rd_addr9, error_addr9;
    logic [15:0] wr_data9, rd_data9;

    logic [15:0] mem  [32];
    logic [15:0] mem9 [32];
    logic        mem_clr, corrupt_en;
    logic [4:0]  corrupt_addr;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t sbq[$];
    wr_t sbq9[$];

    typedef struct {
        string name;
        int    stall_addr;
        int    stall_len;
        int    corrupt;
        int    exp_cycle;
        int    exp_err;
        int    exp_err_addr;
    } vec_t;
    vec_t vecs [3];

    int passed = 0;
    int total  = 0;
    int cyc, stall_addr, stall_left, hold_cnt, max_rd, acc_cnt;

    user_code_loader u_dut (
        .clock(clk), .reset_n(reset_n),
        .b0I(rom[0]), .b1I(rom[1]), .b2I(rom[2]), .b3I(rom[3]),
        .b4I(rom[4]), .b5I(rom[5]), .b6I(rom[6]), .b7I(rom[7]),
        .b8I(rom[8]), .b9I(rom[9]), .b10I(rom[10]), .b11I(rom[11]),
        .b12I(rom[12]), .b13I(rom[13]), .b14I(rom[14]), .b15I(rom[15]),
        .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .cpu_hold(cpu_hold), .done(done),
        .error(error), .error_addr(error_addr)
    );

    user_code_loader #(.BASE_ADDR(0), .NUM_WORDS(9)) u_dut9 (
        .clock(clk), .reset_n(rst9_n),
        .b0I(rom[0]), .b1I(rom[1]), .b2I(rom[2]), .b3I(rom[3]),
        .b4I(rom[4]), .b5I(rom[5]), .b6I(rom[6]), .b7I(rom[7]),
        .b8I(rom[8]), .b9I(rom[9]), .b10I(rom[10]), .b11I(rom[11]),
        .b12I(rom[12]), .b13I(rom[13]), .b14I(rom[14]), .b15I(rom[15]),
        .start(1'b0), .wr_en(wr_en9), .wr_addr(wr_addr9),
        .wr_data(wr_data9), .wr_ready(1'b1), .rd_addr(rd_addr9),
        .rd_data(rd_data9), .cpu_hold(cpu_hold9), .done(done9),
        .error(error9), .error_addr(error_addr9)
    );

    // Instruction memory models: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 32; k++) begin
                mem[k]  <= 16'hDEAD;
                mem9[k] <= 16'hDEAD;
            end
        end else begin
            if (wr_en && wr_ready) mem[wr_addr] <= wr_data;
            if (wr_en9) mem9[wr_addr9] <= wr_data9;
        end
        rd_data <= mem[rd_addr] ^
                   ((corrupt_en && rd_addr == corrupt_addr) ? 16'h0001 : 16'h0000);
        rd_data9 <= mem9[rd_addr9];
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_load(input int base, input int n, input bit nine);
        for (int j = 0; j < n; j++) begin
            if (nine) sbq9.push_back('{5'(base + j), rom[j]});
            else      sbq.push_back('{5'(base + j), rom[j]});
        end
    endtask

    // Called at a negedge: drive wr_ready, then score the write that
    // the coming rising edge will accept.
    task automatic drive_and_mon();
        wr_t x;
        if (wr_en && int'(wr_addr) == stall_addr && wr_data == 16'h9E00)
            hold_cnt++;
        wr_ready = 1'b1;
        if (stall_left > 0 && wr_en && int'(wr_addr) == stall_addr) begin
            wr_ready = 1'b0;
            stall_left--;
        end
        if (reset_n && int'(rd_addr) > max_rd) max_rd = int'(rd_addr);
        #1;
        if (reset_n && wr_en && wr_ready) begin
            acc_cnt++;
            check("wr_pending", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(x.a));
                check("wr_data", 64'(wr_data), 64'(x.d));
            end
        end
    endtask

    // Returns the rising-edge count at which done or error became visible.
    task automatic run_until(input int budget, output int edges);
        edges = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done || error) begin
                edges = cyc;
                break;
            end
            drive_and_mon();
        end
    endtask

    initial begin
        int e, s;
        vec_t v;
        for (int k = 0; k < 16; k++) rom[k] = 16'h1000 + 16'(k) * 16'h0111;
        rom[0]  = 16'h5401;
        rom[4]  = 16'h9E00;
        rom[15] = 16'h0000;
        reset_n = 1'b0; rst9_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
        corrupt_en = 1'b0; corrupt_addr = '0; mem_clr = 1'b0;
        stall_addr = -1; stall_left = 0; hold_cnt = 0; max_rd = 0;
        acc_cnt = 0; cyc = 0;

        // Cycle 1 is the clock period in which reset_n is released, so
        // state visible after rising edge n belongs to cycle n+1.
        // A mismatch on word k is decided at edge NUM_WORDS+2k+3.
        vecs[0] = '{"plain",   -1, 0, -1, 50, 0, 0};
        vecs[1] = '{"stall20", 20, 3, -1, 53, 0, 0};
        vecs[2] = '{"bad23",   -1, 0, 23, 34, 1, 23};

        for (int i = 0; i < 3; i++) begin
            v = vecs[i];
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            check({v.name, "_rst"},
                  64'({wr_en, wr_addr, wr_data, rd_addr, cpu_hold,
                       done, error, error_addr}),
                  64'({1'b0, 5'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0}));
            corrupt_en   = (v.corrupt >= 0);
            corrupt_addr = 5'(v.corrupt);
            stall_addr   = v.stall_addr;
            stall_left   = v.stall_len;
            hold_cnt = 0; max_rd = 0; acc_cnt = 0;
            mem_clr = 1'b1;
            @(negedge clk);
            mem_clr = 1'b0;
            sbq.delete();
            push_load(16, 16, 1'b0);
            wr_ready = 1'b1;
            reset_n  = 1'b1;
            cyc = 0;
            run_until(200, e);
            check({v.name, "_cycle"}, 64'(e + 1), 64'(v.exp_cycle));
            check({v.name, "_done"}, 64'(done), 64'(v.exp_err == 0));
            check({v.name, "_hold"}, 64'(cpu_hold), 64'(v.exp_err != 0));
            check({v.name, "_error"}, 64'(error), 64'(v.exp_err));
            check({v.name, "_eaddr"}, 64'(error_addr), 64'(v.exp_err_addr));
            check({v.name, "_sb_empty"}, 64'(sbq.size()), 64'd0);
            if (v.stall_addr >= 0)
                check({v.name, "_hold_cnt"}, 64'(hold_cnt), 64'd4);
            if (v.exp_err != 0)
                check({v.name, "_max_rd"}, 64'(max_rd), 64'(v.exp_err_addr));
        end

        // Recover from FAIL: memory fixed, start pulse, full reload.
        corrupt_en = 1'b0;
        stall_addr = -1; stall_left = 0;
        push_load(16, 16, 1'b0);
        start = 1'b1;
        @(posedge clk);
        cyc++;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        check("rec_err_clr", 64'(error), 64'd0);
        check("rec_eaddr_clr", 64'(error_addr), 64'd0);
        check("rec_hold", 64'({cpu_hold, done}), 64'(2'b10));
        drive_and_mon();
        run_until(200, e);
        check("rec_further", 64'(e - s), 64'd48);
        check("rec_done", 64'({done, error, cpu_hold}), 64'(3'b100));
        check("rec_sb_empty", 64'(sbq.size()), 64'd0);

        // Abort a load with reset after the 6th accepted write.
        @(negedge clk);
        reset_n = 1'b0;
        sbq.delete();
        push_load(16, 16, 1'b0);
        acc_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        while (acc_cnt < 6 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            drive_and_mon();
        end
        check("abort_acc", 64'(acc_cnt), 64'd6);
        @(posedge clk);
        #2;
        check("abort_wr_en_pre", 64'(wr_en), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_async",
              64'({wr_en, cpu_hold, done, wr_addr}),
              64'({1'b0, 1'b1, 1'b0, 5'd0}));
        sbq.delete();
        @(negedge clk);
        push_load(16, 16, 1'b0);
        reset_n = 1'b1;
        cyc = 0;
        run_until(200, e);
        check("abort_cycle", 64'(e + 1), 64'd50);
        check("abort_done", 64'({done, error, cpu_hold}), 64'(3'b100));
        check("abort_sb_empty", 64'(sbq.size()), 64'd0);

        // Nine-word image based at address 0.
        @(negedge clk);
        sbq9.delete();
        push_load(0, 9, 1'b1);
        rst9_n = 1'b1;
        cyc = 0;
        e = -1;
        for (int i = 0; i < 100; i++) begin
            wr_t x;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done9 || error9) begin
                e = cyc;
                break;
            end
            if (wr_en9) begin
                check("n9_pending", 64'(sbq9.size() > 0), 64'd1);
                if (sbq9.size() > 0) begin
                    x = sbq9.pop_front();
                    check("n9_wr_addr", 64'(wr_addr9), 64'(x.a));
                    check("n9_wr_data", 64'(wr_data9), 64'(x.d));
                end
            end
        end
        check("n9_cycle", 64'(e + 1), 64'd29);
        check("n9_done", 64'({done9, error9, cpu_hold9}), 64'(3'b100));
        check("n9_sb_empty", 64'(sbq9.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
